// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbitration mode type for the round-robin arbiter
package arb_pkg;

    typedef enum logic {
        ARB_NOLOCK,
        ARB_LOCK
    } arb_mode_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational masked first-set search starting at a rotating pointer
//   req     : request vector, bit i = requester i
//   ptr     : highest-priority index for this search
//   pick    : one-hot of the selected requester (zero if none)
//   pick_id : binary index of the selected requester (zero if none)
//   any     : at least one request is present
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] pick_id,
    output logic           any
);

    // Two passes over the request vector: the first only looks at indices at
    // or above ptr, the second covers the wrapped-around part below ptr.
    // The first hit wins, which yields the ptr-upward circular scan.
    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any     = 1'b1;
                pick[i] = 1'b1;
                pick_id = IDW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any     = 1'b1;
                pick[i] = 1'b1;
                pick_id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - registered round-robin arbiter with optional grant locking
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-high reset
//   req       : request lines, bit i = requester i
//   gnt       : registered one-hot grant, zero when idle
//   gnt_id    : binary index of the granted requester, zero when idle
//   gnt_valid : high when any grant is asserted
module round_robin_arbiter
    import arb_pkg::*;
#(
    parameter int        N        = 4,
    parameter arb_mode_e MODE     = ARB_LOCK,
    parameter int        MAX_HOLD = 0,
    localparam int       IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);

    localparam int              HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]   HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_SAT = '1;
    localparam logic [IDW-1:0]  PTR_LAST = IDW'(N - 1);

    logic [IDW-1:0] ptr;
    logic [HW-1:0]  hold_cnt;

    logic [N-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic [IDW-1:0] ptr_n;
    logic [HW-1:0]  hold_n;

    logic [N-1:0]   pick;
    logic [IDW-1:0] pick_id;
    logic           any;
    logic           holding;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (any)
    );

    always_comb begin
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        ptr_n    = ptr;
        hold_n   = hold_cnt;

        // The holder keeps the grant only while it still requests and its
        // hold budget is not used up; |(gnt & req) already implies a grant.
        holding = (MODE == ARB_LOCK) && (|(gnt & req)) &&
                  ((MAX_HOLD == 0) || (hold_cnt < HOLD_LIM));

        if (holding) begin
            if (hold_cnt != HOLD_SAT) begin
                hold_n = hold_cnt + 1'b1;
            end
        end else if (any) begin
            // A forced rotation still goes through the normal scan, so a
            // sole requester is simply re-granted with a fresh hold count.
            gnt_n    = pick;
            gnt_id_n = pick_id;
            ptr_n    = (pick_id == PTR_LAST) ? '0 : pick_id + 1'b1;
            hold_n   = HW'(1);
        end else begin
            gnt_n    = '0;
            gnt_id_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, SHALL be legal for 1..32.
REQ-002 Parameter MODE, default ARB_LOCK: ARB_NOLOCK re-arbitrates every cycle; ARB_LOCK holds a grant while its request stays high.
REQ-003 Parameter MAX_HOLD, default 0: maximum consecutive locked-grant cycles before forced rotation; 0 means unlimited.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N  request lines, bit i = requester i.
REQ-007 gnt  output  N  registered one-hot grant, or all-zero when idle.
REQ-008 gnt_id  output  IDW = max(1,$clog2(N))  binary index of the granted requester, 0 when idle.
REQ-009 gnt_valid  output  1  high iff gnt is nonzero.

Function
REQ-010 gnt SHALL be one-hot or zero in every cycle; gnt_id and gnt_valid SHALL be consistent with gnt in the same cycle.
REQ-011 Latency: grant outputs SHALL reflect the req sampled at the previous rising edge (one-cycle registered latency); there is no combinational path from req to gnt.
REQ-012 Internal state: priority pointer ptr (IDW bits), grant register, hold counter (width sufficient for MAX_HOLD).
REQ-013 Arbitration pick: the first set req bit scanning from index ptr upward, wrapping N-1 -> 0.
REQ-014 On each pick: gnt <= one-hot(pick); ptr <= pick+1, wrapping N-1 -> 0; hold counter <= 1.
REQ-015 req all zero and no hold: gnt <= 0; ptr unchanged.
REQ-016 ARB_LOCK, hold condition: gnt_valid and req[gnt_id] high and (MAX_HOLD==0 or hold counter < MAX_HOLD) -> gnt, ptr unchanged, hold counter +1, saturating.
REQ-017 ARB_LOCK, granted requester drops req: re-arbitrate the same cycle per REQ-013..015; the grant deasserts or moves on the next edge, never with an idle gap when other requests are pending.
REQ-018 ARB_LOCK, MAX_HOLD reached while still requesting: forced re-arbitration; the holder is excluded only by ptr position, so if it is the sole requester it SHALL be re-granted with the hold counter reset to 1.
REQ-019 ARB_NOLOCK: REQ-013/014 applied every cycle a request is present; hold counter unused.
REQ-020 Fairness: with all N requests continuously high, each requester SHALL be granted once in every N-cycle window (ARB_NOLOCK or MAX_HOLD=1).
REQ-021 N=1: gnt SHALL equal req delayed one cycle; ptr stays 0.

Reset
REQ-022 Asserting rst SHALL immediately force gnt=0, gnt_id=0, gnt_valid=0, ptr=0, hold counter=0, including mid-grant.
REQ-023 First edge after rst deassertion SHALL arbitrate from ptr=0 (requester 0 highest).

Structure
REQ-024 Package arb_pkg SHALL hold typedef enum arb_mode_e {ARB_NOLOCK, ARB_LOCK} and nothing block-specific beyond it.
REQ-025 One sub-module rr_pick SHALL implement the combinational masked first-set search (inputs req, ptr; outputs pick one-hot, pick index, any); the top holds all registers.

Verification (N=4 unless stated)
REQ-026 NOLOCK, req=4'b1111 held 8 cycles after reset -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-027 LOCK, MAX_HOLD=0, req=4'b0110 held 5 cycles, then req=4'b0100 -> gnt=0010 for 5 cycles, then 0100 on the following edge, no idle cycle.
REQ-028 LOCK, MAX_HOLD=2, req=4'b1001 held -> gnt 0001,0001,1000,1000,0001,...
REQ-029 Wrap: grant to requester 3 (ptr=0 after), then req=4'b1001 in NOLOCK -> gnt=0001 next; req=0 -> gnt=0000, gnt_valid=0, gnt_id=0.
REQ-030 rst pulsed asynchronously mid-grant (gnt=0100) -> outputs zero before next edge; after release with req=4'b1100 -> gnt=0100 (ptr=0 scan).
REQ-031 Assertions throughout: $onehot0(gnt); gnt_valid==|gnt; gnt implies req was set in the prior cycle.
